// File: rtl/booth_mul_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : booth_mul_pipe
// Description : Three-stage radix-4 Booth multiplier with per-operand
//               signedness, sideband tag and valid/ready flow control.
//               S1 registers operands and Booth digit controls, S2 builds the
//               partial products and compresses them with a carry-save tree,
//               S3 performs the final carry-propagate add.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                 mul_clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 x_signed,
  input  logic                 y_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [TAG_W-1:0]     out_tag
);

  // Extended operand width, number of Booth digits, product width.
  localparam int c_EW     = WIDTH + 2;
  localparam int c_ND     = WIDTH / 2 + 1;
  localparam int c_PW     = 2 * WIDTH;
  // Upper bound on carry-save levels; 33 rows need only 8.
  localparam int c_LEVELS = 16;
  localparam logic [c_PW-1:0] c_ONE = c_PW'(1);

  // --------------------------------------------------------------------------
  // Flow control: every stage moves together when the output can drain.
  // --------------------------------------------------------------------------
  logic            w_advance;
  logic            r_out_valid;

  assign w_advance = ~r_out_valid | out_ready;
  assign in_ready  = w_advance;

  // --------------------------------------------------------------------------
  // Operand extension and Booth encoding (feeds the S1 register).
  // Extending by two bits lets the top digit see the true sign of y and
  // keeps +/-2x representable without overflow.
  // --------------------------------------------------------------------------
  logic [c_EW-1:0] w_x_ext;
  logic [c_EW-1:0] w_y_ext;
  logic [c_ND-1:0] w_neg;
  logic [c_ND-1:0] w_one;
  logic [c_ND-1:0] w_two;

  assign w_x_ext = {{2{x_signed & x[WIDTH-1]}}, x};
  assign w_y_ext = {{2{y_signed & y[WIDTH-1]}}, y};

  generate
    for (genvar gi = 0; gi < c_ND; gi++) begin : g_booth_enc
      logic w_b0;
      logic w_b1;
      logic w_b2;
      if (gi == 0) begin : g_lsb
        assign w_b0 = 1'b0;
      end else begin : g_upper
        assign w_b0 = w_y_ext[2*gi-1];
      end
      assign w_b1 = w_y_ext[2*gi];
      assign w_b2 = w_y_ext[2*gi+1];
      // Digit = -2*b2 + b1 + b0, split into sign / magnitude-1 / magnitude-2.
      assign w_neg[gi] = w_b2;
      assign w_one[gi] = w_b1 ^ w_b0;
      assign w_two[gi] = (w_b2 & ~w_b1 & ~w_b0) | (~w_b2 & w_b1 & w_b0);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Stage 1 registers
  // --------------------------------------------------------------------------
  logic             r_s1_valid;
  logic [c_EW-1:0]  r_s1_x;
  logic [c_ND-1:0]  r_s1_neg;
  logic [c_ND-1:0]  r_s1_one;
  logic [c_ND-1:0]  r_s1_two;
  logic [TAG_W-1:0] r_s1_tag;

  // S1: capture the extended multiplicand and the digit controls on accept.
  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_neg   <= '0;
      r_s1_one   <= '0;
      r_s1_two   <= '0;
      r_s1_tag   <= '0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_x   <= w_x_ext;
        r_s1_neg <= w_neg;
        r_s1_one <= w_one;
        r_s1_two <= w_two;
        r_s1_tag <= in_tag;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: partial product generation
  // --------------------------------------------------------------------------
  logic [c_PW-1:0] w_x_wide;
  logic [c_PW-1:0] w_pp [c_ND];

  assign w_x_wide = {{(c_PW-c_EW){r_s1_x[c_EW-1]}}, r_s1_x};

  generate
    for (genvar gi = 0; gi < c_ND; gi++) begin : g_pp
      logic [c_PW-1:0] w_mag;
      logic [c_PW-1:0] w_sgn;
      assign w_mag = r_s1_two[gi] ? (w_x_wide << 1)
                   : (r_s1_one[gi] ? w_x_wide : '0);
      // Two's complement negate; a "-0" digit yields zero as well.
      assign w_sgn = r_s1_neg[gi] ? (~w_mag + c_ONE) : w_mag;
      assign w_pp[gi] = w_sgn << (2 * gi);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Stage 2: carry-save (Wallace) reduction to a sum/carry pair
  // --------------------------------------------------------------------------
  logic [c_PW-1:0] w_sum;
  logic [c_PW-1:0] w_carry;

  // Compress rows three at a time per level until only two rows remain.
  always_comb begin
    logic [c_PW-1:0] cur [c_ND];
    logic [c_PW-1:0] nxt [c_ND];
    logic [c_PW-1:0] a;
    logic [c_PW-1:0] b;
    logic [c_PW-1:0] c;
    int n;
    int m;
    a = '0;
    b = '0;
    c = '0;
    m = 0;
    for (int i = 0; i < c_ND; i++) begin
      cur[i] = w_pp[i];
      nxt[i] = '0;
    end
    n = c_ND;
    for (int lvl = 0; lvl < c_LEVELS; lvl++) begin
      if (n > 2) begin
        for (int i = 0; i < c_ND; i++) nxt[i] = '0;
        m = 0;
        for (int g = 0; g < c_ND / 3; g++) begin
          if (3 * g + 2 < n) begin
            a = cur[3*g];
            b = cur[3*g+1];
            c = cur[3*g+2];
            nxt[m]   = a ^ b ^ c;
            nxt[m+1] = ((a & b) | (a & c) | (b & c)) << 1;
            m = m + 2;
          end
        end
        // Rows left over from the grouping pass straight to the next level.
        for (int i = 0; i < c_ND; i++) begin
          if (i >= (n / 3) * 3 && i < n) begin
            nxt[m] = cur[i];
            m = m + 1;
          end
        end
        cur = nxt;
        n   = m;
      end
    end
    w_sum   = cur[0];
    w_carry = (n > 1) ? cur[1] : '0;
  end

  // --------------------------------------------------------------------------
  // Stage 2 registers
  // --------------------------------------------------------------------------
  logic             r_s2_valid;
  logic [c_PW-1:0]  r_s2_sum;
  logic [c_PW-1:0]  r_s2_carry;
  logic [TAG_W-1:0] r_s2_tag;

  // S2: register the redundant sum/carry form of the product.
  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_carry <= '0;
      r_s2_tag   <= '0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sum   <= w_sum;
      r_s2_carry <= w_carry;
      r_s2_tag   <= r_s1_tag;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: final carry-propagate add into the output register
  // --------------------------------------------------------------------------
  logic [c_PW-1:0]  r_result;
  logic [TAG_W-1:0] r_out_tag;

  // S3: resolve the product; output holds while the consumer stalls.
  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_out_tag   <= '0;
    end else if (w_advance) begin
      r_out_valid <= r_s2_valid;
      r_result    <= r_s2_sum + r_s2_carry;
      r_out_tag   <= r_s2_tag;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign out_tag   = r_out_tag;

endmodule
`default_nettype wire

// File: doc/booth_mul_pipe.md
BOOTH_MUL_PIPE -- requirements
Module: booth_mul_pipe

Interface
- REQ-001 SHALL have parameter WIDTH, default 32, operand width; even, 8..64.
- REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each operation.
- REQ-003 SHALL have port mul_clk, input, 1, clock; all state updates on its rising edge.
- REQ-004 SHALL have port resetn, input, 1, reset; synchronous, active-low.
- REQ-005 SHALL have port in_valid, input, 1, operation offered.
- REQ-006 SHALL have port in_ready, output, 1, block accepts operation this cycle.
- REQ-007 SHALL have port x, input, WIDTH, multiplicand.
- REQ-008 SHALL have port y, input, WIDTH, multiplier.
- REQ-009 SHALL have port x_signed, input, 1, 1 = x is two's complement, 0 = unsigned.
- REQ-010 SHALL have port y_signed, input, 1, same meaning for y.
- REQ-011 SHALL have port in_tag, input, TAG_W, sideband returned with the result.
- REQ-012 SHALL have port out_valid, output, 1, result available.
- REQ-013 SHALL have port out_ready, input, 1, consumer takes result.
- REQ-014 SHALL have port result, output, 2*WIDTH, full product.
- REQ-015 SHALL have port out_tag, output, TAG_W, tag of the op in result.

Function
- REQ-016 SHALL accept an op on a cycle where in_valid & in_ready are both high; SHALL ignore x, y, x_signed, y_signed and in_tag otherwise.
- REQ-017 SHALL extend each operand to WIDTH+2 bits, using sign extension when its signed flag is 1 and zero extension otherwise.
- REQ-018 SHALL form radix-4 Booth digits from the extended y with an implicit y[-1]=0: digit count WIDTH/2+1, each digit in {-2,-1,0,+1,+2}.
- REQ-019 SHALL form one partial product per digit from the extended x, shifted 2*i, computed modulo 2^(2*WIDTH).
- REQ-020 SHALL have three pipeline stages:
  - S1: register operands and Booth-encode.
  - S2: generate partial products and reduce them via a carry-save (Wallace) tree to two vectors, registered.
  - S3: final carry-propagate add, registered into result.
- REQ-021 SHALL set result = (x as interpreted) * (y as interpreted) mod 2^(2*WIDTH); the result is exact for all four signedness combinations.
- REQ-022 SHALL assert out_valid for an accepted op on the 3rd rising edge after acceptance, when there is no backpressure.
- REQ-023 SHALL give each stage a valid bit; a stage's valid bit and data SHALL move forward only when advance = ~out_valid | out_ready.
- REQ-024 SHALL drive in_ready = advance, combinationally; bubbles (invalid stages) SHALL propagate and never produce out_valid.
- REQ-025 SHALL hold result, out_tag and out_valid stable while out_valid & ~out_ready.
- REQ-026 SHALL sustain one op per cycle with no gaps while out_ready stays high.
- REQ-027 SHALL deliver results in acceptance order, and out_tag SHALL equal the in_tag of the same op.
- REQ-028 SHALL, on simultaneous out handshake and in handshake in one cycle, advance the pipeline and accept the new op with no loss or duplication.

Reset
- REQ-029 SHALL, on a cycle with resetn low at the edge, clear all stage valid bits and set out_valid=0, result=0, out_tag=0.
- REQ-030 SHALL discard all in-flight ops on reset mid-operation; none SHALL appear after reset.
- REQ-031 SHALL not accept an op on a cycle in which resetn is low.
- REQ-032 SHALL allow in_ready to be 1 on the first cycle after reset release.

Verification (WIDTH=32 unless stated)
- REQ-033 SHALL check: x=0xFFFFFFFF, y=0xFFFFFFFF, both signed, tag 3 -> result 0x0000000000000001, out_tag 3, out_valid exactly 3 cycles after accept.
- REQ-034 SHALL check: same operands, both unsigned -> 0xFFFFFFFE00000001; with x_signed=1, y_signed=0 -> 0xFFFFFFFF00000001.
- REQ-035 SHALL check: x=y=0x80000000 signed -> 0x4000000000000000; x=0x7FFFFFFF signed, y=0x80000000 signed -> 0xC000000080000000.
- REQ-036 SHALL check: 6 back-to-back ops with tags 0..5, out_ready low for 5 cycles mid-stream -> in_ready low while stalled, output held stable, all 6 results correct in tag order, no duplicates.
- REQ-037 SHALL check: resetn low for 1 cycle with 3 ops in flight -> out_valid 0, result 0 next cycle, no stale result afterwards.
- REQ-038 SHALL check: WIDTH=8 instance, exhaustive 256x256 operand pairs x 4 signedness modes against a reference product model, with random out_ready.
